// File: rtl/f1_lights_out.sv
// F1 lights-out reaction timer: sequences the start lights, holds a
// random delay with all lights on, then times the driver's button press.
module f1_lights_out #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 button,
  input  logic [7:0]           lights_in,
  output logic                 fsm_en,
  output logic                 seq_clr,
  output logic [7:0]           lights_out,
  output logic [CNT_WIDTH-1:0] react_time,
  output logic                 react_valid,
  output logic                 false_start
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEQ,
    S_DELAY,
    S_REACT,
    S_DONE,
    S_FAULT
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q;
  state_e               state_d;
  logic [6:0]           lfsr_q;
  logic [6:0]           lfsr_d;
  logic [6:0]           dly_q;
  logic [6:0]           dly_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] rt_q;
  logic [CNT_WIDTH-1:0] rt_d;
  logic                 rv_q;
  logic                 rv_d;
  logic                 dly_last;
  logic                 restart;

  // LFSR free-runs every cycle; taps 7 and 6 give a 127-long sequence
  assign lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

  // Reaction count including the current tick, stuck at all-ones
  assign cnt_inc = (tick && (cnt_q != CntMax)) ? cnt_q + CntOne
                                                : cnt_q;

  assign dly_last = (dly_q == 7'd1);

  assign restart = start &&
                   ((state_q == S_IDLE) ||
                    (state_q == S_DONE) ||
                    (state_q == S_FAULT));

  assign react_time  = rt_q;
  assign react_valid = rv_q;
  assign false_start = (state_q == S_FAULT);

  // State register and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= 7'h01;
      dly_q   <= 7'd0;
      cnt_q   <= '0;
      rt_q    <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      rt_q    <= rt_d;
      rv_q    <= rv_d;
    end
  end

  // Next-state logic; a false start beats a same-cycle delay expiry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) state_d = S_SEQ;
      end
      S_SEQ: begin
        if (lights_in == 8'hFF) state_d = S_DELAY;
      end
      S_DELAY: begin
        if (button) begin
          state_d = S_FAULT;
        end else if (tick && dly_last) begin
          state_d = S_REACT;
        end
      end
      S_REACT: begin
        if (button) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Delay load/countdown, reaction counting and result capture
  always_comb begin
    dly_d = dly_q;
    cnt_d = cnt_q;
    rt_d  = rt_q;
    rv_d  = 1'b0;
    unique case (state_q)
      S_SEQ: begin
        if (lights_in == 8'hFF) dly_d = lfsr_q;
      end
      S_DELAY: begin
        if (!button && tick) begin
          dly_d = dly_q - 7'd1;
          if (dly_last) cnt_d = '0;
        end
      end
      S_REACT: begin
        cnt_d = cnt_inc;
        if (button) begin
          rt_d = cnt_inc;
          rv_d = 1'b1;
        end
      end
      default: begin
        dly_d = dly_q;
      end
    endcase
  end

  // Display and upstream-FSM controls; forced quiet while in reset
  always_comb begin
    fsm_en     = 1'b0;
    seq_clr    = 1'b0;
    lights_out = 8'h00;
    if (!rst) begin
      seq_clr = restart;
      unique case (state_q)
        S_SEQ: begin
          lights_out = lights_in;
          fsm_en     = tick;
        end
        S_DELAY: begin
          lights_out = 8'hFF;
        end
        default: begin
          lights_out = 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f1_lights_out.sv
// Randomised race sequences against a race-level reference model;
// results are queued by the driver and checked by a separate monitor.
module tb_f1_lights_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        start;
  logic        button;
  logic [7:0]  lights_in;
  logic        fsm_en;
  logic        seq_clr;
  logic [7:0]  lights_out;
  logic [15:0] react_time;
  logic        react_valid;
  logic        false_start;
  logic        fsm_en4;
  logic        seq_clr4;
  logic [7:0]  lights_out4;
  logic [3:0]  react_time4;
  logic        react_valid4;
  logic        false_start4;

  always #5 clk = ~clk;

  f1_lights_out #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .button(button), .lights_in(lights_in),
    .fsm_en(fsm_en), .seq_clr(seq_clr),
    .lights_out(lights_out), .react_time(react_time),
    .react_valid(react_valid), .false_start(false_start)
  );

  f1_lights_out #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .button(button), .lights_in(lights_in),
    .fsm_en(fsm_en4), .seq_clr(seq_clr4),
    .lights_out(lights_out4), .react_time(react_time4),
    .react_valid(react_valid4), .false_start(false_start4)
  );

  typedef struct {
    bit fault;
    int rt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   since = 0;
  int   last_rt = 0;
  bit   last_fault = 1'b0;

  // cycles since the last reset edge: indexes the LFSR sequence
  always @(posedge clk) since <= rst ? 0 : since + 1;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // value of the x^7+x^6+1 sequence n steps after seed 1
  function automatic int lfsr_at(int n);
    logic [6:0] v;
    v = 7'h01;
    for (int i = 0; i < (n % 127); i++)
      v = {v[5:0], v[6] ^ v[5]};
    return int'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(string ph, int lo, int fe);
    #3;
    chk({ph, "_lights"}, lights_out, lo);
    chk({ph, "_fsm_en"}, fsm_en, fe);
    chk({ph, "_seq_clr"}, seq_clr, 0);
  endtask

  // mode: 0 normal, 1 false start on final tick,
  //       2 false start at random point, 3 reset during REACT
  task automatic race(int p, int r, int bt, int mode, bit all_tick);
    int   n;
    int   ticks;
    int   c;
    int   ph;
    int   kfs;
    bit   tk;
    exp_t e;
    start = 1'b1;
    tick = 1'($urandom_range(0, 1));
    button = 1'b0;
    lights_in = 8'($urandom);
    #3;
    chk("start_seq_clr", seq_clr, 1);
    chk("start_lights", lights_out, 0);
    chk("start_fsm_en", fsm_en, 0);
    chk("held_react_time", react_time, last_rt);
    chk("held_false_start", false_start, last_fault);
    step();
    for (int k = 0; k <= 8; k++) begin
      lights_in = 8'((1 << k) - 1);
      tk = all_tick ? 1'b1 : 1'($urandom_range(0, 1));
      tick = tk;
      button = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      if (k == 8) n = lfsr_at(since);
      outs("seq", int'(lights_in), int'(tk));
      step();
    end
    ph = $urandom_range(0, p - 1);
    c = 0;
    ticks = 0;
    kfs = $urandom_range(0, n - 1);
    while (ticks < n) begin
      tk = ((c % p) == ph);
      c++;
      tick = tk;
      start = 1'($urandom_range(0, 1));
      lights_in = 8'($urandom);
      button = 1'b0;
      if (mode == 1 && tk && ticks == n - 1) button = 1'b1;
      if (mode == 2 && ticks == kfs) button = 1'b1;
      if (button) begin
        e.fault = 1'b1;
        e.rt = 0;
        sb.push_back(e);
      end
      outs("delay", 8'hFF, 0);
      step();
      if (button) break;
      if (tk) ticks++;
    end
    button = 1'b0;
    if (mode == 1 || mode == 2) begin
      start = 1'b0;
      tick = 1'($urandom_range(0, 1));
      #3;
      chk("fault_lights", lights_out, 0);
      chk("fault_flag", false_start, 1);
      chk("fault_no_valid", react_valid, 0);
      last_fault = 1'b1;
      step();
      return;
    end
    last_fault = 1'b0;
    ph = $urandom_range(0, p - 1);
    c = 0;
    ticks = 0;
    while (ticks < r) begin
      tk = ((c % p) == ph);
      c++;
      tick = tk;
      start = 1'($urandom_range(0, 1));
      outs("react", 0, 0);
      step();
      if (tk) ticks++;
    end
    if (mode == 3) begin
      rst = 1'b1;
      tick = 1'b1;
      start = 1'b1;
      button = 1'b1;
      lights_in = 8'hFF;
      outs("in_reset", 0, 0);
      step();
      rst = 1'b0;
      start = 1'b0;
      button = 1'b0;
      tick = 1'b0;
      #3;
      chk("rst_lights", lights_out, 0);
      chk("rst_react_time", react_time, 0);
      chk("rst_react_valid", react_valid, 0);
      chk("rst_false_start", false_start, 0);
      last_rt = 0;
      step();
      return;
    end
    button = 1'b1;
    tick = 1'(bt);
    start = 1'b0;
    e.fault = 1'b0;
    e.rt = r + bt;
    sb.push_back(e);
    outs("press", 0, 0);
    step();
    button = 1'b0;
    tick = 1'b0;
    last_rt = r + bt;
    #3;
    chk("done_lights", lights_out, 0);
    step();
  endtask

  // monitor: pops the scoreboard on every result the DUT presents
  initial begin
    bit   prv = 1'b0;
    bit   pfs = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (react_valid) begin
        chk("valid_single_cycle", prv, 0);
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result_kind_valid", e.fault, 0);
          chk("react_time", react_time, e.rt);
          chk("react_time_w4", react_time4,
              (e.rt > 15) ? 15 : e.rt);
          chk("react_valid_w4", react_valid4, 1);
        end
      end
      if (false_start && !pfs) begin
        if (sb.size() == 0) begin
          chk("unexpected_fault", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result_kind_fault", e.fault, 1);
          chk("fault_valid_low", react_valid, 0);
        end
      end
      prv = react_valid;
      pfs = false_start;
    end
  end

  initial begin
    int md;
    rst = 1'b1;
    tick = 1'b1;
    start = 1'b1;
    button = 1'b0;
    lights_in = 8'hFF;
    step();
    step();
    outs("reset", 0, 0);
    chk("reset_react_time", react_time, 0);
    chk("reset_react_valid", react_valid, 0);
    chk("reset_false_start", false_start, 0);
    step();
    rst = 1'b0;
    start = 1'b0;
    tick = 1'b0;
    step();
    race(4, 37, 0, 0, 1'b1);
    race(2, 20, 0, 0, 1'b0);
    race(3, 5, 1, 1, 1'b0);
    race(2, 10, 0, 3, 1'b0);
    race(1, 15, 1, 0, 1'b1);
    race(2, 8, 0, 2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      md = $urandom_range(0, 5);
      if (md > 3) md = 0;
      race($urandom_range(1, 4), $urandom_range(0, 40),
           $urandom_range(0, 1), md, 1'b0);
    end
    repeat (5) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
